pattern_chaser: RTL and testbench
=================================

# pattern_chaser

Parametrised LED-pattern generator for tile user designs: a synchronous prescaler with runtime-selectable division ratio drives a WIDTH-bit pattern register that steps in Johnson, ring, bounce or binary mode, in either direction. It supersedes hand-built ripple-divider/shift-chain chasers. All logic runs in the single tile clock domain; the prescaler produces step enables, not derived clocks.

## Interface
- PRESCALE_W, 17: prescaler counter width.
- TAP_BASE, 9: prescaler bit used when sel = 0.
- SEL_W, 3: width of sel. Legal only if TAP_BASE + 2^SEL_W − 1 ≤ PRESCALE_W − 1.
- WIDTH, 6: pattern width. Must be ≥ 2.

Ports:
- clk  in  1  tile clock.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  high: prescaler runs and pattern may step. Low: both hold.
- clr  in  1  synchronous clear. Highest priority after rst_n.
- sel  in  SEL_W  tap select; tap = TAP_BASE + sel.
- mode  in  2  00 Johnson, 01 ring, 10 bounce, 11 binary.
- dir  in  1  0 = up/left, 1 = down/right.
- pattern  out  WIDTH  registered pattern.
- tick  out  1  registered one-cycle pulse on each step edge.
- wrap  out  1  registered one-cycle pulse when a step lands on the mode seed.
- div_out  out  1  pre_cnt[tap]; square wave with period 2^(tap+1) cycles.

## Operation
- Reset values: pre_cnt = 0, pattern = 0, mode_q = 00, bdir = up, tick = 0, wrap = 0.
- Seeds by mode:
  - Johnson: 0.
  - Ring: 1.
  - Bounce: 1, with bdir = up.
  - Binary: 0.
- Step condition: step = en & (pre_cnt[tap:0] all ones). pre_cnt increments when en = 1 and wraps at 2^PRESCALE_W.
- Per-edge priority:
  1. clr: pre_cnt ← 0, pattern ← seed(mode), mode_q ← mode, bdir ← up, tick ← 0, wrap ← 0.
  2. mode ≠ mode_q (evaluated regardless of en): pattern ← seed(mode), mode_q ← mode, bdir ← up, wrap ← 0, no step. pre_cnt and tick behave normally.
  3. step: tick ← 1, pattern ← next, wrap ← (next == seed).
  4. Otherwise: pattern holds, tick ← 0, wrap ← 0.
- Next pattern by mode:
  - Johnson, dir 0: {p[W-2:0], ~p[W-1]}. dir 1: {~p[0], p[W-1:1]}. Period 2·WIDTH steps.
  - Ring: rotate left (dir 0) or right (dir 1). Period WIDTH steps.
  - Bounce: one-hot, moves in direction bdir; dir is ignored. At bit WIDTH−1 moving up, next = bit WIDTH−2 and bdir ← down. At bit 0 moving down, next = bit 1 and bdir ← up. Period 2·WIDTH − 2 steps.
  - Binary: p + 1 (dir 0) or p − 1 (dir 1), modulo 2^WIDTH. wrap fires when the result is 0.
- Changes to sel or dir take effect at the next compare or step; no reseed and no prescaler reset.

## Timing
- After reset or clr with en held high, the first step occurs on the 2^(tap+1)-th rising edge. Steps then repeat every 2^(tap+1) cycles.
- tick and pattern update on the same edge; wrap is coincident with the tick of the wrapping step.
- Lowering en freezes pre_cnt, pattern and bdir. tick and wrap read 0 while en is low. Raising en resumes from the frozen prescaler phase.
- rst_n asserted mid-run clears all state immediately, without waiting for a clock edge.

## Structure
- Shared package pattern_chaser_pkg holds:
  - Mode encodings (MODE_JOHNSON, MODE_RING, MODE_BOUNCE, MODE_BINARY).
  - A seed function of (mode, WIDTH).
- Sub-module chaser_prescaler owns pre_cnt, tap selection, step generation and div_out.
- The top level owns pattern, bdir, mode_q, tick and wrap.

## Test plan
Parameters: PRESCALE_W = 6, TAP_BASE = 0, SEL_W = 2, WIDTH = 4.
- Reset; then mode = 00, dir = 0, sel = 0, en = 1.
  - Required: a step every 2 cycles, sequence 0000→0001→0011→0111→1111→1110→1100→1000→0000.
  - wrap fires only on the 8th step.
- sel = 3.
  - Required: tick every 16 cycles; div_out high 8 cycles, low 8 cycles.
  - Switching to sel = 1 mid-run gives ticks every 4 cycles, with no reset of pattern.
- mode = 10.
  - Required: 0001→0010→0100→1000→0100→0010→0001, wrap on the 6th step.
  - Toggling dir mid-bounce changes nothing.
- Johnson pattern at 0111, then mode → 01 with dir = 1.
  - Required: next edge gives 0001 with no wrap; the following steps give 1000, then 0100.
- mode = 11, dir = 1, starting from 0000.
  - Required: 1111 with no wrap; then 1110, and so on down to 0001→0000 with wrap.
- en low for 10 cycles mid-run.
  - Required: pattern and div_out frozen; tick = 0.
- clr pulse at pattern 0011.
  - Required: next edge gives pattern = seed and pre_cnt = 0.
- rst_n pulsed low between clock edges.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/pattern_chaser_pkg.sv
// pattern_chaser shared types.
// Mode encodings and per-mode seed values.
package pattern_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'b00,
    MODE_RING    = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_BINARY  = 2'b11
  } mode_e;

  localparam logic BDIR_UP   = 1'b0;
  localparam logic BDIR_DOWN = 1'b1;

  function automatic logic [63:0] seed_of(
    mode_e       m,
    int unsigned w
  );
    logic [63:0] s;
    s = '0;
    if (w != 0 && (m == MODE_RING || m == MODE_BOUNCE))
      s[0] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/pattern_chaser_if.sv
// pattern_chaser control/status bundle.
// master drives controls, slave returns pattern.
interface pattern_chaser_if #(
  parameter int SEL_W = 3,
  parameter int WIDTH = 6
);
  logic             en;
  logic             clr;
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic             dir;
  logic [WIDTH-1:0] pattern;
  logic             tick;
  logic             wrap;
  logic             div_out;

  modport master (
    output en, clr, sel, mode, dir,
    input  pattern, tick, wrap, div_out
  );

  modport slave (
    input  en, clr, sel, mode, dir,
    output pattern, tick, wrap, div_out
  );
endinterface

// File: rtl/chaser_prescaler.sv
// Free-running prescaler with selectable tap.
// Emits step enables; no derived clocks.
module chaser_prescaler #(
  parameter int PRESCALE_W = 17,
  parameter int TAP_BASE   = 9,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  output logic             step,
  output logic             div_out
);

  localparam int TAP_W = $clog2(PRESCALE_W);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] mask;
  logic [TAP_W-1:0]      tap;

  // tap index and low-bit mask pre_cnt[tap:0]
  always_comb begin
    tap  = TAP_W'(TAP_BASE) + TAP_W'(sel);
    mask = '0;
    for (int i = 0; i < PRESCALE_W; i++)
      mask[i] = (i <= int'(tap));
  end

  assign step    = en & ((pre_cnt & mask) == mask);
  assign div_out = pre_cnt[tap];

  // counter: clear wins, otherwise count while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_cnt <= '0;
    else if (clr)
      pre_cnt <= '0;
    else if (en)
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
  end

endmodule

// File: rtl/pattern_chaser.sv
// LED pattern chaser: Johnson/ring/bounce/binary.
// Pattern steps on prescaler enables.
module pattern_chaser
  import pattern_chaser_pkg::*;
#(
  parameter int PRESCALE_W = 17,
  parameter int TAP_BASE   = 9,
  parameter int SEL_W      = 3,
  parameter int WIDTH      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  pattern_chaser_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             step;
  mode_e            mode_in;
  mode_e            mode_q;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] pat_nxt;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] seed_q;
  logic             bdir_q;
  logic             bdir_nxt;
  logic             tick_q;
  logic             wrap_q;

  chaser_prescaler #(
    .PRESCALE_W(PRESCALE_W),
    .TAP_BASE  (TAP_BASE),
    .SEL_W     (SEL_W)
  ) u_pre (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .clr    (bus.clr),
    .sel    (bus.sel),
    .step   (step),
    .div_out(bus.div_out)
  );

  assign mode_in = mode_e'(bus.mode);
  assign seed_in = WIDTH'(seed_of(mode_in, WIDTH));
  assign seed_q  = WIDTH'(seed_of(mode_q, WIDTH));

  // next pattern and bounce direction for a step
  always_comb begin
    pat_nxt  = pattern_q;
    bdir_nxt = bdir_q;
    unique case (mode_q)
      MODE_JOHNSON:
        pat_nxt = bus.dir
          ? {~pattern_q[0], pattern_q[WIDTH-1:1]}
          : {pattern_q[WIDTH-2:0], ~pattern_q[WIDTH-1]};
      MODE_RING:
        pat_nxt = bus.dir
          ? {pattern_q[0], pattern_q[WIDTH-1:1]}
          : {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
      MODE_BOUNCE:
        if (bdir_q == BDIR_UP) begin
          if (pattern_q[WIDTH-1]) begin
            pat_nxt  = pattern_q >> 1;
            bdir_nxt = BDIR_DOWN;
          end else begin
            pat_nxt = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            pat_nxt  = pattern_q << 1;
            bdir_nxt = BDIR_UP;
          end else begin
            pat_nxt = pattern_q >> 1;
          end
        end
      default:
        pat_nxt = bus.dir ? pattern_q - ONE
                          : pattern_q + ONE;
    endcase
  end

  // clear, then reseed on mode change, then step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      mode_q    <= MODE_JOHNSON;
      bdir_q    <= BDIR_UP;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (bus.clr) begin
      pattern_q <= seed_in;
      mode_q    <= mode_in;
      bdir_q    <= BDIR_UP;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (mode_in != mode_q) begin
      pattern_q <= seed_in;
      mode_q    <= mode_in;
      bdir_q    <= BDIR_UP;
      tick_q    <= step;
      wrap_q    <= 1'b0;
    end else if (step) begin
      pattern_q <= pat_nxt;
      bdir_q    <= bdir_nxt;
      tick_q    <= 1'b1;
      wrap_q    <= (pat_nxt == seed_q);
    end else begin
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pattern_chaser.sv
// pattern_chaser bench: directed scenarios plus
// randomized run against a behavioural model.
module tb_pattern_chaser;

  localparam int PRESCALE_W = 6;
  localparam int TAP_BASE   = 0;
  localparam int SEL_W      = 2;
  localparam int WIDTH      = 4;
  localparam int N          = 1 << WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pattern_chaser_if #(.SEL_W(SEL_W), .WIDTH(WIDTH)) bus ();

  pattern_chaser #(
    .PRESCALE_W(PRESCALE_W),
    .TAP_BASE  (TAP_BASE),
    .SEL_W     (SEL_W),
    .WIDTH     (WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int m_cnt, m_pat, m_mode;
  bit m_down, m_tick, m_wrap;

  function automatic int seed(int md);
    return (md == 1 || md == 2) ? 1 : 0;
  endfunction

  function automatic int m_div();
    return (m_cnt >> (TAP_BASE + int'(bus.sel))) & 1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pat = 0; m_mode = 0;
    m_down = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic step_pattern(int d);
    int pos;
    case (m_mode)
      0: m_pat = (d == 0)
           ? (m_pat * 2) % N + ((m_pat < N / 2) ? 1 : 0)
           : m_pat / 2 + ((m_pat % 2 == 0) ? N / 2 : 0);
      1: m_pat = (d == 0)
           ? (m_pat * 2) % N + m_pat / (N / 2)
           : m_pat / 2 + (m_pat % 2) * (N / 2);
      2: begin
        pos = $clog2(m_pat);
        if (!m_down) begin
          if (pos == WIDTH - 1) begin pos--; m_down = 1; end
          else pos++;
        end else begin
          if (pos == 0) begin pos = 1; m_down = 0; end
          else pos--;
        end
        m_pat = 1 << pos;
      end
      default: m_pat = (d == 0) ? (m_pat + 1) % N
                                : (m_pat + N - 1) % N;
    endcase
  endtask

  // one rising edge: update model from current inputs
  task automatic adv();
    int per;
    bit stp;
    if (!rst_n) model_reset();
    else begin
      per = 2 << (TAP_BASE + int'(bus.sel));
      stp = bus.en && (m_cnt % per == per - 1);
      if (bus.clr) begin
        m_cnt = 0; m_pat = seed(int'(bus.mode));
        m_mode = int'(bus.mode);
        m_down = 0; m_tick = 0; m_wrap = 0;
      end else begin
        if (bus.en) m_cnt = (m_cnt + 1) % (1 << PRESCALE_W);
        if (int'(bus.mode) != m_mode) begin
          m_mode = int'(bus.mode);
          m_pat = seed(m_mode);
          m_down = 0; m_tick = stp; m_wrap = 0;
        end else if (stp) begin
          step_pattern(int'(bus.dir));
          m_tick = 1;
          m_wrap = (m_pat == seed(m_mode));
        end else begin
          m_tick = 0; m_wrap = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1; bus.clr = 0; bus.sel = 0;
    bus.mode = 0; bus.dir = 0;
    rst_n = 0;
    model_reset();
    adv(); adv();
    checks++;
    if (bus.pattern !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pattern: got %b expected 0000", bus.pattern);
    end
    checks++;
    if ({bus.tick, bus.wrap, bus.div_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.tick, bus.wrap, bus.div_out});
    end
    rst_n = 1;
  endtask

  task automatic test_johnson();
    logic [3:0] exp_seq [8] = '{4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    int k = 0;
    for (int i = 1; i <= 40 && k < 8; i++) begin
      adv();
      checks++;
      if (bus.pattern !== 4'(m_pat) || bus.tick !== m_tick
          || bus.wrap !== m_wrap) begin
        errors++;
        $display("FAIL johnson_model: got %b/%b/%b expected %b/%b/%b",
          bus.pattern, bus.tick, bus.wrap, 4'(m_pat), m_tick, m_wrap);
      end
      if (bus.tick === 1'b1) begin
        checks++;
        if (bus.pattern !== exp_seq[k] || bus.wrap !== (k == 7)
            || i != 2 * (k + 1)) begin
          errors++;
          $display("FAIL johnson_seq: step %0d edge %0d got %b wrap %b expected %b",
            k, i, bus.pattern, bus.wrap, exp_seq[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL johnson_steps: got %0d expected 8", k);
    end
  endtask

  task automatic test_sel();
    int last = -1;
    int ntk = 0;
    logic [3:0] prev;
    bus.sel = 3;
    for (int i = 0; i < 64; i++) begin
      adv();
      checks++;
      if (bus.tick !== m_tick || bus.div_out !== 1'(m_div())) begin
        errors++;
        $display("FAIL sel3_model: got tick %b div %b expected %b %b",
          bus.tick, bus.div_out, m_tick, 1'(m_div()));
      end
      if (bus.tick === 1'b1) begin
        ntk++;
        if (last >= 0) begin
          checks++;
          if (i - last != 16) begin
            errors++;
            $display("FAIL sel3_period: got %0d expected 16", i - last);
          end
        end
        last = i;
      end
    end
    checks++;
    if (ntk != 4) begin
      errors++;
      $display("FAIL sel3_count: got %0d expected 4", ntk);
    end
    prev = bus.pattern;
    bus.sel = 1;
    last = -1;
    ntk = 0;
    for (int i = 0; i < 16; i++) begin
      adv();
      checks++;
      if (bus.pattern !== 4'(m_pat) || bus.tick !== m_tick) begin
        errors++;
        $display("FAIL sel1_model: got %b/%b expected %b/%b",
          bus.pattern, bus.tick, 4'(m_pat), m_tick);
      end
      if (i == 0 && bus.tick === 1'b0) begin
        checks++;
        if (bus.pattern !== prev) begin
          errors++;
          $display("FAIL sel1_noreset: got %b expected %b", bus.pattern, prev);
        end
      end
      if (bus.tick === 1'b1) begin
        ntk++;
        if (last >= 0) begin
          checks++;
          if (i - last != 4) begin
            errors++;
            $display("FAIL sel1_period: got %0d expected 4", i - last);
          end
        end
        last = i;
      end
    end
    checks++;
    if (ntk != 4) begin
      errors++;
      $display("FAIL sel1_count: got %0d expected 4", ntk);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [6] = '{4'b0010, 4'b0100, 4'b1000,
      4'b0100, 4'b0010, 4'b0001};
    int k = 0;
    bus.sel = 0; bus.mode = 2; bus.dir = 0;
    adv();
    checks++;
    if (bus.pattern !== 4'b0001 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL bounce_seed: got %b wrap %b expected 0001 0",
        bus.pattern, bus.wrap);
    end
    for (int i = 0; i < 40 && k < 6; i++) begin
      adv();
      checks++;
      if (bus.pattern !== 4'(m_pat) || bus.wrap !== m_wrap) begin
        errors++;
        $display("FAIL bounce_model: got %b/%b expected %b/%b",
          bus.pattern, bus.wrap, 4'(m_pat), m_wrap);
      end
      if (bus.tick === 1'b1) begin
        checks++;
        if (bus.pattern !== exp_seq[k] || bus.wrap !== (k == 5)) begin
          errors++;
          $display("FAIL bounce_seq: step %0d got %b wrap %b expected %b",
            k, bus.pattern, bus.wrap, exp_seq[k]);
        end
        k++;
        if (k == 2 || k == 4) bus.dir = ~bus.dir;
      end
    end
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL bounce_steps: got %0d expected 6", k);
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_seq [2] = '{4'b1000, 4'b0100};
    int k = 0;
    bit found = 0;
    bus.mode = 0; bus.dir = 0; bus.sel = 0; bus.clr = 1;
    adv();
    bus.clr = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      if (bus.pattern === 4'b0111) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL switch_reach: got %b expected 0111", bus.pattern);
    end
    bus.mode = 1; bus.dir = 1;
    adv();
    checks++;
    if (bus.pattern !== 4'b0001 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL switch_reseed: got %b wrap %b expected 0001 0",
        bus.pattern, bus.wrap);
    end
    for (int i = 0; i < 20 && k < 2; i++) begin
      adv();
      if (bus.tick === 1'b1) begin
        checks++;
        if (bus.pattern !== exp_seq[k]) begin
          errors++;
          $display("FAIL switch_ring: step %0d got %b expected %b",
            k, bus.pattern, exp_seq[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL switch_steps: got %0d expected 2", k);
    end
  endtask

  task automatic test_binary();
    int k = 0;
    bus.mode = 3; bus.dir = 1;
    adv();
    checks++;
    if (bus.pattern !== 4'b0000) begin
      errors++;
      $display("FAIL binary_seed: got %b expected 0000", bus.pattern);
    end
    for (int i = 0; i < 100 && k < 16; i++) begin
      adv();
      if (bus.tick === 1'b1) begin
        checks++;
        if (bus.pattern !== 4'((15 - k) % 16) || bus.wrap !== (k == 15)) begin
          errors++;
          $display("FAIL binary_seq: step %0d got %b wrap %b expected %b",
            k, bus.pattern, bus.wrap, 4'((15 - k) % 16));
        end
        k++;
      end
    end
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL binary_steps: got %0d expected 16", k);
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] pat;
    logic div;
    bus.mode = 0; bus.dir = 0; bus.sel = 1;
    repeat (7) adv();
    bus.en = 0;
    adv();
    pat = bus.pattern;
    div = bus.div_out;
    for (int i = 0; i < 9; i++) begin
      adv();
      checks++;
      if (bus.pattern !== pat || bus.div_out !== div
          || bus.tick !== 1'b0 || bus.pattern !== 4'(m_pat)) begin
        errors++;
        $display("FAIL hold: got %b/%b/%b expected %b/%b/0",
          bus.pattern, bus.div_out, bus.tick, pat, div);
      end
    end
    bus.en = 1;
    for (int i = 0; i < 8; i++) begin
      adv();
      checks++;
      if (bus.pattern !== 4'(m_pat) || bus.tick !== m_tick
          || bus.div_out !== 1'(m_div())) begin
        errors++;
        $display("FAIL resume: got %b/%b/%b expected %b/%b/%b",
          bus.pattern, bus.tick, bus.div_out,
          4'(m_pat), m_tick, 1'(m_div()));
      end
    end
  endtask

  task automatic test_clr();
    bit found = 0;
    int n = 0;
    bus.clr = 1;
    adv();
    bus.clr = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv();
      if (bus.pattern === 4'b0011) found = 1;
    end
    bus.clr = 1;
    adv();
    bus.clr = 0;
    checks++;
    if (!found || bus.pattern !== 4'b0000 || bus.div_out !== 1'b0
        || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL clr: got %b div %b tick %b expected 0000 0 0",
        bus.pattern, bus.div_out, bus.tick);
    end
    for (int i = 1; i <= 20 && n == 0; i++) begin
      adv();
      if (bus.tick === 1'b1) n = i;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL clr_first_step: got edge %0d expected 4", n);
    end
  endtask

  task automatic test_async_reset();
    bus.mode = 1; bus.dir = 0;
    repeat (5) adv();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (bus.pattern !== 4'b0000 || bus.tick !== 1'b0
        || bus.wrap !== 1'b0 || bus.div_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %b/%b/%b/%b expected 0000/0/0/0",
        bus.pattern, bus.tick, bus.wrap, bus.div_out);
    end
    #2;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.en  = ($urandom_range(0, 9) != 0);
      bus.clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 39) == 0) bus.sel = 2'($urandom_range(0, 3));
      adv();
      checks++;
      if (bus.pattern !== 4'(m_pat) || bus.tick !== m_tick
          || bus.wrap !== m_wrap || bus.div_out !== 1'(m_div())) begin
        errors++;
        $display("FAIL random %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
          i, bus.pattern, bus.tick, bus.wrap, bus.div_out,
          4'(m_pat), m_tick, m_wrap, 1'(m_div()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_sel();
    test_bounce();
    test_mode_switch();
    test_binary();
    test_enable_hold();
    test_clr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
